// File: rtl/m_axi_flow_fifo.sv
// m_axi_flow_fifo: FWFT FIFO of any depth with almost-full/empty thresholds, flush and sticky error flags.
module m_axi_flow_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow
);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 2);
    logic [DATA_WIDTH-1:0] mem [DEPTH-1];
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic                  push, pop, out_load, mem_empty, mem_wr, mem_rd;
    assign if_full_n         = cnt != FULL_CNT;
    assign if_empty_n        = cnt != '0;
    assign if_num_data_valid = cnt;
    assign if_almost_full    = cnt >= AF_CNT;
    assign if_almost_empty   = cnt <= AE_CNT;
    // The output register holds the head whenever cnt > 0, so storage holds cnt-1 words.
    always_comb begin
        push      = if_write && if_full_n && clk_en && !flush;
        pop       = if_read && if_empty_n && clk_en && !flush;
        out_load  = !if_empty_n || pop;
        mem_empty = cnt <= (ADDR_WIDTH + 1)'(1);
        mem_rd    = out_load && !mem_empty;
        mem_wr    = push && !(out_load && mem_empty);
    end
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wptr] <= if_din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            if_dout      <= '0;
            if_overflow  <= 1'b0;
            if_underflow <= 1'b0;
        end else if (clk_en) begin
            if_overflow  <= if_overflow || (if_write && !if_full_n);
            if_underflow <= if_underflow || (if_read && !if_empty_n);
            if (flush) begin
                cnt  <= '0;
                wptr <= '0;
                rptr <= '0;
            end else begin
                cnt  <= cnt + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
                wptr <= mem_wr ? (wptr == LAST ? '0 : wptr + 1'b1) : wptr;
                rptr <= mem_rd ? (rptr == LAST ? '0 : rptr + 1'b1) : rptr;
                if (out_load) if_dout <= mem_rd ? mem[rptr] : (push ? if_din : if_dout);
            end
        end
    end
endmodule
